alu8_seq: RTL and testbench

ALU8_SEQ -- requirements
Module: alu8_seq

---
 rtl/alu8_pkg.sv | 30 +++
 rtl/alu8_seq_if.sv | 45 ++++
 rtl/alu8_seq.sv | 111 +++++++++++
 tb/tb_alu8_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu8_pkg.sv
// Shared definitions for the alu8 sequencer: opcodes, FSM state encoding,
// datapath width and the latched command payload.
package alu8_pkg;

  localparam int unsigned W    = 8;
  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b010;
  localparam logic [OP_W-1:0] OP_OR   = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b101;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b110;
  localparam logic [OP_W-1:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [W-1:0]    data;
    logic            ld;
    logic            wb;
  } cmd_t;

endpackage

// File: rtl/alu8_seq_if.sv
// Bundle of the command, result and alu8-facing signals of alu8_seq.
interface alu8_seq_if;
  import alu8_pkg::*;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [OP_W-1:0] cmd_op;
  logic [W-1:0]    cmd_data;
  logic            cmd_ld;
  logic            cmd_wb;

  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [OP_W-1:0] alu_op;
  logic [W-1:0]    alu_y;
  logic            alu_z;
  logic            alu_c;
  logic            alu_v;

  logic            res_valid;
  logic            res_ready;
  logic [W-1:0]    res_data;
  logic            res_z;
  logic            res_c;
  logic            res_v;

  logic [W-1:0]    acc;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_ld, cmd_wb,
    input  alu_y, alu_z, alu_c, alu_v,
    input  res_ready,
    output cmd_ready, alu_a, alu_b, alu_op,
    output res_valid, res_data, res_z, res_c, res_v, acc
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_ld, cmd_wb,
    output alu_y, alu_z, alu_c, alu_v,
    output res_ready,
    input  cmd_ready, alu_a, alu_b, alu_op,
    input  res_valid, res_data, res_z, res_c, res_v, acc
  );

endinterface

// File: rtl/alu8_seq.sv
// Accumulator sequencer in front of an external combinational alu8:
// accepts one command, runs it through the ALU for one cycle, holds the result.
module alu8_seq
  import alu8_pkg::state_e, alu8_pkg::cmd_t, alu8_pkg::S_IDLE,
         alu8_pkg::S_EXEC, alu8_pkg::S_HOLD, alu8_pkg::OP_PASS;
#(
  parameter int unsigned W = 8  // only 8 matches the downstream alu8
) (
  input  logic       clk,
  input  logic       rst,
  alu8_seq_if.slave  bus
);

  state_e       state_q, state_d;
  cmd_t         cmd_q, cmd_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] res_data_q, res_data_d;
  logic         res_z_q, res_z_d;
  logic         res_c_q, res_c_d;
  logic         res_v_q, res_v_d;
  logic         res_valid_q, res_valid_d;

  // Next-state, command latch, result capture and accumulator update
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    acc_d       = acc_q;
    res_data_d  = res_data_q;
    res_z_d     = res_z_q;
    res_c_d     = res_c_q;
    res_v_d     = res_v_q;
    res_valid_d = res_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d.op   = bus.cmd_op;
          cmd_d.data = bus.cmd_data;
          cmd_d.ld   = bus.cmd_ld;
          cmd_d.wb   = bus.cmd_wb;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        res_valid_d = 1'b1;
        state_d     = S_HOLD;
        // A load bypasses the ALU entirely and takes precedence over wb
        if (cmd_q.ld) begin
          res_data_d = cmd_q.data;
          res_z_d    = (cmd_q.data == '0);
          res_c_d    = 1'b0;
          res_v_d    = 1'b0;
          acc_d      = cmd_q.data;
        end else begin
          res_data_d = bus.alu_y;
          res_z_d    = bus.alu_z;
          res_c_d    = bus.alu_c;
          res_v_d    = bus.alu_v;
          if (cmd_q.wb) begin
            acc_d = bus.alu_y;
          end
        end
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      acc_q       <= '0;
      res_data_q  <= '0;
      res_z_q     <= 1'b0;
      res_c_q     <= 1'b0;
      res_v_q     <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      acc_q       <= acc_d;
      res_data_q  <= res_data_d;
      res_z_q     <= res_z_d;
      res_c_q     <= res_c_d;
      res_v_q     <= res_v_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Outside EXEC the ALU idles as a pass-through of ACC
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.alu_a     = acc_q;
  assign bus.alu_b     = (state_q == S_EXEC) ? cmd_q.data : '0;
  assign bus.alu_op    = (state_q == S_EXEC) ? cmd_q.op   : OP_PASS;

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_z     = res_z_q;
  assign bus.res_c     = res_c_q;
  assign bus.res_v     = res_v_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_alu8_seq.sv
// Directed, table-driven bench for alu8_seq with a behavioural alu8 stand-in.
module tb_alu8_seq;
  import alu8_pkg::*;

  logic clk;
  logic rst;
  alu8_seq_if bus ();

  alu8_seq #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // alu8 stand-in: C is carry-out on add, borrow on sub, shifted-out bit on shifts
  logic [8:0] m_t;
  logic [7:0] m_y;
  logic       m_c, m_v;
  always_comb begin
    m_t = '0;
    m_y = '0;
    m_c = 1'b0;
    m_v = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin
        m_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        m_y = m_t[7:0];
        m_c = m_t[8];
        m_v = (bus.alu_a[7] == bus.alu_b[7]) && (m_y[7] != bus.alu_a[7]);
      end
      OP_SUB: begin
        m_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        m_y = m_t[7:0];
        m_c = m_t[8];
        m_v = (bus.alu_a[7] != bus.alu_b[7]) && (m_y[7] != bus.alu_a[7]);
      end
      OP_AND:  m_y = bus.alu_a & bus.alu_b;
      OP_OR:   m_y = bus.alu_a | bus.alu_b;
      OP_XOR:  m_y = bus.alu_a ^ bus.alu_b;
      OP_SHL: begin
        m_y = {bus.alu_a[6:0], 1'b0};
        m_c = bus.alu_a[7];
      end
      OP_SHR: begin
        m_y = {1'b0, bus.alu_a[7:1]};
        m_c = bus.alu_a[0];
      end
      default: m_y = bus.alu_a;
    endcase
  end
  assign bus.alu_y = m_y;
  assign bus.alu_z = (m_y == 8'h00);
  assign bus.alu_c = m_c;
  assign bus.alu_v = m_v;

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic       ld;
    logic       wb;
    logic [7:0] y;
    logic       z;
    logic       c;
    logic       v;
    logic [7:0] acc;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Offer a command and return #1 after the edge that accepts it (DUT in EXEC)
  task automatic send(input logic [2:0] op, input logic [7:0] d, input logic ld, input logic wb);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_ld    = ld;
    bus.cmd_wb    = wb;
    while (!bus.cmd_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready wait", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic release_res();
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{OP_ADD,  8'h05, 1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 8'h05};
    vecs[1]  = '{OP_ADD,  8'h03, 1'b0, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 8'h08};
    vecs[2]  = '{OP_ADD,  8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{OP_SUB,  8'h01, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{OP_ADD,  8'h7F, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 8'h7F};
    vecs[5]  = '{OP_ADD,  8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 8'h80};
    vecs[6]  = '{OP_SHL,  8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[7]  = '{OP_ADD,  8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF};
    vecs[8]  = '{OP_ADD,  8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[9]  = '{OP_ADD,  8'hAA, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'hAA};
    vecs[10] = '{OP_AND,  8'h0F, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 8'h0A};
    vecs[11] = '{OP_OR,   8'hF0, 1'b0, 1'b0, 8'hFA, 1'b0, 1'b0, 1'b0, 8'h0A};
    vecs[12] = '{OP_XOR,  8'hFF, 1'b0, 1'b1, 8'hF5, 1'b0, 1'b0, 1'b0, 8'hF5};
    vecs[13] = '{OP_SHR,  8'h00, 1'b0, 1'b1, 8'h7A, 1'b0, 1'b1, 1'b0, 8'h7A};
    vecs[14] = '{OP_PASS, 8'h33, 1'b0, 1'b1, 8'h7A, 1'b0, 1'b0, 1'b0, 8'h7A};
    vecs[15] = '{OP_SUB,  8'h7B, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF};
    vecs[16] = '{OP_ADD,  8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 8'h80};
    vecs[17] = '{OP_SUB,  8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1, 8'h7F};

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_data  = 8'h00;
    bus.cmd_ld    = 1'b0;
    bus.cmd_wb    = 1'b0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst acc",       32'(bus.acc),       32'h00);
    chk("rst res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst res_data",  32'(bus.res_data),  32'h00);
    chk("rst flags",     32'({bus.res_z, bus.res_c, bus.res_v}), 32'd0);
    chk("rst alu_op",    32'(bus.alu_op),    32'(OP_PASS));
    chk("rst alu_b",     32'(bus.alu_b),     32'h00);

    for (int i = 0; i < NV; i++) begin
      send(vecs[i].op, vecs[i].data, vecs[i].ld, vecs[i].wb);
      chk($sformatf("v%0d exec alu_op", i),    32'(bus.alu_op),    32'(vecs[i].op));
      chk($sformatf("v%0d exec alu_b", i),     32'(bus.alu_b),     32'(vecs[i].data));
      chk($sformatf("v%0d exec res_valid", i), 32'(bus.res_valid), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d res_valid", i), 32'(bus.res_valid), 32'd1);
      chk($sformatf("v%0d res_data", i),  32'(bus.res_data),  32'(vecs[i].y));
      chk($sformatf("v%0d zcv", i), 32'({bus.res_z, bus.res_c, bus.res_v}),
          32'({vecs[i].z, vecs[i].c, vecs[i].v}));
      chk($sformatf("v%0d acc", i),       32'(bus.acc),       32'(vecs[i].acc));
      chk($sformatf("v%0d hold ready", i), 32'(bus.cmd_ready), 32'd0);
      chk($sformatf("v%0d hold alu_op", i), 32'(bus.alu_op),   32'(OP_PASS));
      chk($sformatf("v%0d hold alu_b", i),  32'(bus.alu_b),    32'h00);
      release_res();
    end

    // Back-pressure with a second command pending throughout HOLD
    send(OP_ADD, 8'h01, 1'b0, 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_data  = 8'h3C;
    bus.cmd_ld    = 1'b1;
    bus.cmd_wb    = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d cmd_ready", k), 32'(bus.cmd_ready), 32'd0);
      chk($sformatf("bp%0d res_valid", k), 32'(bus.res_valid), 32'd1);
      chk($sformatf("bp%0d res_data", k),  32'(bus.res_data),  32'h80);
      chk($sformatf("bp%0d zcv", k), 32'({bus.res_z, bus.res_c, bus.res_v}), 32'b001);
      chk($sformatf("bp%0d acc", k),       32'(bus.acc),       32'h7F);
      @(posedge clk);
      #1;
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    chk("bp idle cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("bp idle res_valid", 32'(bus.res_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("bp second accepted", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("bp second res_data", 32'(bus.res_data), 32'h3C);
    chk("bp second acc",      32'(bus.acc),      32'h3C);
    release_res();

    // Reset during EXEC must abort the writeback
    send(OP_ADD, 8'h10, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("mr ld acc", 32'(bus.acc), 32'h10);
    release_res();
    send(OP_ADD, 8'h10, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mr acc",       32'(bus.acc),       32'h00);
    chk("mr res_valid", 32'(bus.res_valid), 32'd0);
    chk("mr cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mr res_data",  32'(bus.res_data),  32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
